// File: rtl/md_scheduler.sv
// HI/LO sequencer for the multi-cycle mult/div datapath: issues start, counts latency, commits HI/LO.
// Optional MD_DIV0_HOLD_EN: DIV/DIVU with a zero divisor is treated as a no-op.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_E,
  input  logic [2:0]  op_E,
  input  logic [31:0] wdata_E,
  input  logic [31:0] divisor_E,
  input  logic        md_D,
  input  logic [31:0] md_hi_in,
  input  logic [31:0] md_lo_in,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_D,
  output logic        err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [1:0]  op_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        err_nxt;
  logic        arith, mvw, mult_class, div_class, div0_hold;

  assign mult_class = (op_E == 3'd1) || (op_E == 3'd2);
  assign div_class  = (op_E == 3'd3) || (op_E == 3'd4);
  assign arith      = issue_E && (mult_class || div_class);
  assign mvw        = issue_E && ((op_E == 3'd5) || (op_E == 3'd6));

`ifdef MD_DIV0_HOLD_EN
  assign div0_hold = div_class && (divisor_E == '0);
`else
  logic unused_divisor;
  assign unused_divisor = |divisor_E;
  assign div0_hold      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      md_op <= '0;
      hi    <= '0;
      lo    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      md_op <= op_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    op_nxt    = md_op;
    hi_nxt    = hi;
    lo_nxt    = lo;
    err_nxt   = err;
    md_start  = 1'b0;
    case (state)
      IDLE: begin
        if (arith && !div0_hold) begin
          md_start  = 1'b1;
          op_nxt    = 2'(op_E - 3'd1);
          count_nxt = mult_class ? MULT_LOAD : DIV_LOAD;
          state_nxt = RUN;
        end else if (mvw) begin
          if (op_E == 3'd5) hi_nxt = wdata_E;
          else              lo_nxt = wdata_E;
        end
      end
      RUN: begin
        // Anything touching HI/LO here means the D-stage stall was bypassed.
        if (arith || mvw) err_nxt = 1'b1;
        if (count == '0) begin
          hi_nxt    = md_hi_in;
          lo_nxt    = md_lo_in;
          state_nxt = IDLE;
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign stall_D = md_D && (busy || md_start);

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler with default latencies (MULT 5, DIV 10).
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_E = 1'b0;
  logic [2:0]  op_E = '0;
  logic [31:0] wdata_E = '0;
  logic [31:0] divisor_E = 32'd7;
  logic        md_D = 1'b0;
  logic [31:0] md_hi_in = '0;
  logic [31:0] md_lo_in = '0;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] hi, lo;
  logic        busy, stall_D, err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .issue_E(issue_E), .op_E(op_E), .wdata_E(wdata_E),
    .divisor_E(divisor_E), .md_D(md_D), .md_hi_in(md_hi_in), .md_lo_in(md_lo_in),
    .md_start(md_start), .md_op(md_op), .hi(hi), .lo(lo), .busy(busy),
    .stall_D(stall_D), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi c=%0d got %h want 0", c, hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo c=%0d got %h want 0", c, lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c=%0d got %b want 0", c, busy); end
      checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL reset_stall c=%0d got %b want 0", c, stall_D); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err c=%0d got %b want 0", c, err); end
    end
  endtask

  task automatic test_mult;
    tick();
    issue_E = 1'b1; op_E = 3'd1; md_hi_in = 32'h0000_0001; md_lo_in = 32'hFFFF_FFFE;
    #1;
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL mult_start got %b want 1", md_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy0 got %b want 0", busy); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) issue_E = 1'b0;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy c=%0d got %b want 1", c, busy); end
      checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL mult_nostart c=%0d got %b want 0", c, md_start); end
      if (c == 1) begin
        checks++; if (md_op !== 2'd0) begin errors++; $display("FAIL mult_op got %0d want 0", md_op); end
      end
      if (c == 5) begin
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_hi_early got %h want 0", hi); end
      end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_done_busy got %b want 0", busy); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL mult_hi got %h want 00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_divu_stall;
    md_D = 1'b1;
    issue_E = 1'b1; op_E = 3'd4; divisor_E = 32'd7;
    md_hi_in = 32'h1111_1111; md_lo_in = 32'h2222_2222;
    #1;
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL divu_start got %b want 1", md_start); end
    checks++; if (stall_D !== 1'b1) begin errors++; $display("FAIL divu_stall0 got %b want 1", stall_D); end
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) issue_E = 1'b0;
      #1;
      checks++; if (stall_D !== 1'b1) begin errors++; $display("FAIL divu_stall c=%0d got %b want 1", c, stall_D); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy c=%0d got %b want 1", c, busy); end
      if (c == 1) begin
        checks++; if (md_op !== 2'd3) begin errors++; $display("FAIL divu_op got %0d want 3", md_op); end
      end
    end
    tick();
    checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL divu_stall_end got %b want 0", stall_D); end
    checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL divu_hi got %h want 11111111", hi); end
    checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL divu_lo got %h want 22222222", lo); end
    checks++; if (md_op !== 2'd3) begin errors++; $display("FAIL divu_op_hold got %0d want 3", md_op); end
    md_D = 1'b0;
  endtask

  task automatic test_move;
    issue_E = 1'b1; op_E = 3'd5; wdata_E = 32'hDEAD_BEEF;
    #1;
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL mthi_start got %b want 0", md_start); end
    tick();
    issue_E = 1'b0;
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got %h want deadbeef", hi); end
    checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL mthi_lo got %h want 22222222", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", busy); end
    issue_E = 1'b1; op_E = 3'd6; wdata_E = 32'h0BAD_F00D;
    tick();
    issue_E = 1'b0;
    checks++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo_lo got %h want 0badf00d", lo); end
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_hi got %h want deadbeef", hi); end
    issue_E = 1'b1; op_E = 3'd7; wdata_E = 32'h5555_5555;
    #1;
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL rsvd_start got %b want 0", md_start); end
    tick();
    issue_E = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy got %b want 0", busy); end
    checks++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL rsvd_lo got %h want 0badf00d", lo); end
  endtask

  task automatic test_back_to_back;
    issue_E = 1'b1; op_E = 3'd2; md_hi_in = 32'hCAFE_0000; md_lo_in = 32'h0000_CAFE;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) issue_E = 1'b0;
    end
    checks++; if (md_op !== 2'd1) begin errors++; $display("FAIL b2b_op got %0d want 1", md_op); end
    tick();
    checks++; if (hi !== 32'hCAFE_0000) begin errors++; $display("FAIL b2b_hi got %h want cafe0000", hi); end
    issue_E = 1'b1; op_E = 3'd3; divisor_E = 32'd3;
    #1;
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL b2b_start got %b want 1", md_start); end
    tick();
    issue_E = 1'b0;
    checks++; if (md_op !== 2'd2) begin errors++; $display("FAIL b2b_divop got %0d want 2", md_op); end
    for (int c = 2; c <= 11; c++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_div_done got %b want 0", busy); end
  endtask

  task automatic test_collision;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL coll_err0 got %b want 0", err); end
    issue_E = 1'b1; op_E = 3'd1; md_hi_in = 32'hAAAA_0000; md_lo_in = 32'h0000_BBBB;
    tick();
    issue_E = 1'b0;
    tick();
    issue_E = 1'b1; op_E = 3'd1;
    #1;
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL coll_nostart got %b want 0", md_start); end
    tick();
    issue_E = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL coll_err got %b want 1", err); end
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coll_busy5 got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_done got %b want 0", busy); end
    checks++; if (hi !== 32'hAAAA_0000) begin errors++; $display("FAIL coll_hi got %h want aaaa0000", hi); end
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL coll_sticky got %b want 1", err); end
    reset = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL coll_err_clr got %b want 0", err); end
    tick();
    reset = 1'b1;
    tick();
    issue_E = 1'b1; op_E = 3'd1; md_hi_in = 32'h1357_9BDF; md_lo_in = 32'h2468_ACE0;
    tick();
    issue_E = 1'b0;
    tick();
    issue_E = 1'b1; op_E = 3'd5; wdata_E = 32'h1234_5678;
    tick();
    issue_E = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mvw_err got %b want 1", err); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mvw_hi got %h want 0", hi); end
    for (int c = 4; c <= 6; c++) tick();
    checks++; if (hi !== 32'h1357_9BDF) begin errors++; $display("FAIL mvw_commit got %h want 13579bdf", hi); end
    issue_E = 1'b1; op_E = 3'd3; divisor_E = 32'd9;
    tick();
    issue_E = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midrst_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midrst_lo got %h want 0", lo); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_div0;
    tick();
    issue_E = 1'b1; op_E = 3'd5; wdata_E = 32'h7777_7777;
    tick();
    md_D = 1'b1;
    issue_E = 1'b1; op_E = 3'd3; divisor_E = 32'd0;
    md_hi_in = 32'h9999_0000; md_lo_in = 32'h0000_9999;
    #1;
`ifdef MD_DIV0_HOLD_EN
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL div0_start got %b want 0", md_start); end
    checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL div0_stall got %b want 0", stall_D); end
    tick();
    issue_E = 1'b0; md_D = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div0_busy got %b want 0", busy); end
    checks++; if (hi !== 32'h7777_7777) begin errors++; $display("FAIL div0_hi got %h want 77777777", hi); end
`else
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL div0_start got %b want 1", md_start); end
    checks++; if (stall_D !== 1'b1) begin errors++; $display("FAIL div0_stall got %b want 1", stall_D); end
    tick();
    issue_E = 1'b0; md_D = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div0_busy got %b want 1", busy); end
    for (int c = 2; c <= 10; c++) tick();
    checks++; if (hi !== 32'h7777_7777) begin errors++; $display("FAIL div0_hi_early got %h want 77777777", hi); end
    tick();
    checks++; if (hi !== 32'h9999_0000) begin errors++; $display("FAIL div0_hi got %h want 99990000", hi); end
    checks++; if (lo !== 32'h0000_9999) begin errors++; $display("FAIL div0_lo got %h want 00009999", lo); end
`endif
    divisor_E = 32'd7;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_move();
    test_back_to_back();
    test_collision();
    test_div0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
